// File: rtl/mult_share_arbiter_pkg.sv
// Shared widths, FSM encodings and a small helper for the two-requester multiplier arbiter.
package mult_share_arbiter_pkg;
   localparam int M_WIDTH = 2;
   localparam int Q_WIDTH = 3;
   localparam int P_WIDTH = M_WIDTH + Q_WIDTH;

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_CALC = 2'd1;
   localparam logic [1:0] S_RESP = 2'd2;

   function automatic logic [1:0] onehot2(input logic sel);
      return sel ? 2'b10 : 2'b01;
   endfunction
endpackage

// File: rtl/mult_share_arbiter_multcal.sv
// MultCal: combinational unsigned 2-bit x 3-bit multiplier shared by both requesters.
module MultCal
   import mult_share_arbiter_pkg::*;
(
   input  logic [M_WIDTH-1:0] i_m,
   input  logic [Q_WIDTH-1:0] i_q,
   output logic [P_WIDTH-1:0] o_p
);
   assign o_p = P_WIDTH'(i_m) * P_WIDTH'(i_q);
endmodule

// File: rtl/mult_share_arbiter.sv
// Round-robin arbiter sharing one MultCal between two valid/ready requesters,
// sequenced IDLE -> CALC -> RESP with registered operands and product.
module mult_share_arbiter
   import mult_share_arbiter_pkg::*;
(
   input  logic               clock,
   input  logic               reset,
   input  logic [1:0]         req_valid,
   input  logic [M_WIDTH-1:0] req_m0,
   input  logic [Q_WIDTH-1:0] req_q0,
   input  logic [M_WIDTH-1:0] req_m1,
   input  logic [Q_WIDTH-1:0] req_q1,
   output logic [1:0]         req_ready,
   output logic [1:0]         resp_valid,
   output logic [P_WIDTH-1:0] resp_p,
   input  logic [1:0]         resp_ready,
   output logic               busy
);
   logic [1:0]         r_state;
   logic               r_prio;
   logic               r_owner;
   logic [M_WIDTH-1:0] r_op_m;
   logic [Q_WIDTH-1:0] r_op_q;
   logic [P_WIDTH-1:0] r_p;

   logic               w_gnt_vld;
   logic               w_gnt;
   logic               w_idle;
   logic               w_resp;
   logic               w_accept;
   logic [M_WIDTH-1:0] w_sel_m;
   logic [Q_WIDTH-1:0] w_sel_q;
   logic [P_WIDTH-1:0] w_prod;

   // Favoured requester first, otherwise the other one.
   assign w_gnt_vld = req_valid[r_prio] | req_valid[~r_prio];
   assign w_gnt     = req_valid[r_prio] ? r_prio : ~r_prio;
   assign w_sel_m   = w_gnt ? req_m1 : req_m0;
   assign w_sel_q   = w_gnt ? req_q1 : req_q0;

   assign w_idle    = (r_state == S_IDLE);
   assign w_resp    = (r_state == S_RESP);
   assign w_accept  = resp_ready[r_owner];

   MultCal u_multcal (
      .i_m (r_op_m),
      .i_q (r_op_q),
      .o_p (w_prod)
   );

   always_ff @(posedge clock) begin
      if (reset) begin
         r_state <= S_IDLE;
         r_prio  <= 1'b0;
         r_owner <= 1'b0;
         r_op_m  <= '0;
         r_op_q  <= '0;
         r_p     <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_gnt_vld) begin
                  r_op_m  <= w_sel_m;
                  r_op_q  <= w_sel_q;
                  r_owner <= w_gnt;
                  r_state <= S_CALC;
               end
            end
            S_CALC: begin
               r_p     <= w_prod;
               r_state <= S_RESP;
            end
            S_RESP: begin
               if (w_accept) begin
                  r_prio  <= ~r_owner;
                  r_state <= S_IDLE;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   // Outputs are forced quiet while reset is held so nothing leaks in that cycle.
   assign req_ready  = (!reset && w_idle && w_gnt_vld) ? onehot2(w_gnt) : 2'b00;
   assign resp_valid = (!reset && w_resp) ? onehot2(r_owner) : 2'b00;
   assign resp_p     = (!reset && w_resp) ? r_p : '0;
   assign busy       = !reset && !w_idle;
endmodule

// File: tb/tb_mult_share_arbiter.sv
// Directed bench for mult_share_arbiter: handshake, fairness, back-pressure, reset and all operand pairs.
module tb_mult_share_arbiter;
   logic       clock;
   logic       reset;
   logic [1:0] req_valid;
   logic [1:0] req_m0;
   logic [2:0] req_q0;
   logic [1:0] req_m1;
   logic [2:0] req_q1;
   logic [1:0] req_ready;
   logic [1:0] resp_valid;
   logic [4:0] resp_p;
   logic [1:0] resp_ready;
   logic       busy;

   int checks   = 0;
   int failures = 0;

   mult_share_arbiter dut (
      .clock      (clock),
      .reset      (reset),
      .req_valid  (req_valid),
      .req_m0     (req_m0),
      .req_q0     (req_q0),
      .req_m1     (req_m1),
      .req_q1     (req_q1),
      .req_ready  (req_ready),
      .resp_valid (resp_valid),
      .resp_p     (resp_p),
      .resp_ready (resp_ready),
      .busy       (busy)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic check_quiet(input string tag);
      check({tag, ".req_ready"},  8'(req_ready),  8'd0);
      check({tag, ".resp_valid"}, 8'(resp_valid), 8'd0);
      check({tag, ".resp_p"},     8'(resp_p),     8'd0);
      check({tag, ".busy"},       8'(busy),       8'd0);
   endtask

   initial begin
      logic [1:0] exp_g;
      logic [4:0] exp_p;

      reset = 1'b1; req_valid = 2'b00; resp_ready = 2'b00;
      req_m0 = '0; req_q0 = '0; req_m1 = '0; req_q1 = '0;
      step(); step();
      check_quiet("reset");
      reset = 1'b0;

      // Single request 3*7 on requester 0, zero-wait accept
      req_valid = 2'b01; req_m0 = 2'd3; req_q0 = 3'd7; resp_ready = 2'b11;
      #1;
      check("t1.ready", 8'(req_ready), 8'd1);
      check("t1.busy_idle", 8'(busy), 8'd0);
      step();
      req_valid = 2'b00;
      check("t1.calc_ready", 8'(req_ready), 8'd0);
      check("t1.calc_busy", 8'(busy), 8'd1);
      check("t1.calc_rv", 8'(resp_valid), 8'd0);
      step();
      check("t1.rv", 8'(resp_valid), 8'd1);
      check("t1.p", 8'(resp_p), 8'd21);
      check("t1.resp_busy", 8'(busy), 8'd1);
      step();
      check_quiet("t1.done");

      // Both valid after reset: requester 0 first
      reset = 1'b1; step(); reset = 1'b0;
      req_valid = 2'b11; req_m0 = 2'd1; req_q0 = 3'd5; req_m1 = 2'd2; req_q1 = 3'd5;
      #1;
      check("t2.ready0", 8'(req_ready), 8'd1);
      step(); req_valid = 2'b10;
      check("t2.calc_ready", 8'(req_ready), 8'd0);
      step();
      check("t2.rv0", 8'(resp_valid), 8'd1);
      check("t2.p0", 8'(resp_p), 8'd5);
      step();
      check("t2.ready1", 8'(req_ready), 8'd2);
      step(); req_valid = 2'b00;
      step();
      check("t2.rv1", 8'(resp_valid), 8'd2);
      check("t2.p1", 8'(resp_p), 8'd10);
      step();

      // Six operations with both requesters continuously valid
      req_valid = 2'b11; req_m0 = 2'd3; req_q0 = 3'd2; req_m1 = 2'd1; req_q1 = 3'd7;
      for (int i = 0; i < 6; i++) begin
         exp_g = (i % 2 == 0) ? 2'b01 : 2'b10;
         exp_p = (i % 2 == 0) ? 5'd6 : 5'd7;
         #1;
         check($sformatf("t3.grant%0d", i), 8'(req_ready), 8'(exp_g));
         step(); step();
         check($sformatf("t3.rv%0d", i), 8'(resp_valid), 8'(exp_g));
         check($sformatf("t3.p%0d", i), 8'(resp_p), 8'(exp_p));
         step();
      end

      // Back-pressure on requester 1 while requester 0 waits
      req_valid = 2'b10; req_m1 = 2'd2; req_q1 = 3'd6; resp_ready = 2'b00;
      #1;
      check("t4.ready1", 8'(req_ready), 8'd2);
      step();
      req_valid = 2'b11; req_m0 = 2'd2; req_q0 = 3'd3;
      step();
      resp_ready = 2'b01;
      for (int i = 0; i < 5; i++) begin
         check($sformatf("t4.hold_rv%0d", i), 8'(resp_valid), 8'd2);
         check($sformatf("t4.hold_p%0d", i), 8'(resp_p), 8'd12);
         check($sformatf("t4.hold_ready%0d", i), 8'(req_ready), 8'd0);
         step();
      end
      resp_ready = 2'b10;
      step();
      check("t4.pending_ready0", 8'(req_ready), 8'd1);
      step(); req_valid = 2'b00; resp_ready = 2'b11;
      step();
      check("t4.rv0", 8'(resp_valid), 8'd1);
      check("t4.p0", 8'(resp_p), 8'd6);
      step();

      // Reset during CALC (prio is 1 here)
      req_valid = 2'b10; req_m1 = 2'd3; req_q1 = 3'd3;
      step();
      req_valid = 2'b00;
      check("t5.calc_busy", 8'(busy), 8'd1);
      reset = 1'b1;
      #1;
      check_quiet("t5.reset_held");
      step(); reset = 1'b0;
      check_quiet("t5.after");
      step();
      check("t5.no_resp", 8'(resp_valid), 8'd0);
      req_valid = 2'b11;
      #1;
      check("t5.prio0", 8'(req_ready), 8'd1);
      req_valid = 2'b00;

      // Reset during RESP after serving requester 0 (prio would be 1)
      req_valid = 2'b01; req_m0 = 2'd1; req_q0 = 3'd1;
      step(); req_valid = 2'b00; step(); step();
      req_valid = 2'b10; resp_ready = 2'b00;
      step(); req_valid = 2'b00; step();
      check("t6.resp_rv", 8'(resp_valid), 8'd2);
      check("t6.resp_p", 8'(resp_p), 8'd9);
      reset = 1'b1; resp_ready = 2'b11;
      step(); reset = 1'b0;
      check_quiet("t6.after");
      step();
      check("t6.no_resp", 8'(resp_valid), 8'd0);
      req_valid = 2'b11;
      #1;
      check("t6.prio0", 8'(req_ready), 8'd1);
      req_valid = 2'b00;
      #1;

      // Every operand pair through each requester
      resp_ready = 2'b11;
      for (int r = 0; r < 2; r++) begin
         for (int m = 0; m < 4; m++) begin
            for (int q = 0; q < 8; q++) begin
               exp_g = (r == 0) ? 2'b01 : 2'b10;
               exp_p = 5'(m * q);
               req_m0 = 2'(m); req_q0 = 3'(q); req_m1 = 2'(m); req_q1 = 3'(q);
               req_valid = exp_g;
               #1;
               check($sformatf("ex.r%0d.ready", r), 8'(req_ready), 8'(exp_g));
               step(); req_valid = 2'b00;
               step();
               check($sformatf("ex.r%0d.m%0d.q%0d.rv", r, m, q), 8'(resp_valid), 8'(exp_g));
               check($sformatf("ex.r%0d.m%0d.q%0d.p", r, m, q), 8'(resp_p), 8'(exp_p));
               step();
            end
         end
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
